pipeline_control: RTL and testbench
===================================

PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 SHALL have ports i_Clock in 1 (sole clock, rising edge) and i_Reset_n in 1 (asynchronous, active-low reset).
REQ-002 SHALL have i_ID_Valid in 1 (ID holds a live instruction), i_ID_EnvCall / i_ID_EnvBreak / i_ID_IllegalInstruction in 1 each (decode flags), i_ID_PC in 32.
REQ-003 SHALL have i_ID_rs1 / i_ID_rs2 in 5 each, i_EX_MemRead in 1, i_EX_rd in 5 (load-use detection).
REQ-004 SHALL have i_EX_TakeBranch in 1, i_EX_BranchTarget in 32, i_MEM_Busy in 1 (data cache stall), i_TrapVector in 32, i_Resume in 1.
REQ-005 SHALL have o_IF_Stall / o_ID_Stall / o_IF_Flush / o_ID_Flush in 1 each (o_ID_Flush = bubble into EX), o_PC_Redirect in 1, o_PC_Target in 32.
REQ-006 SHALL have o_TrapTaken in 1 (one-cycle pulse), o_MEPC in 32, o_MCAUSE in 4, o_Halted in 1.

Function
REQ-007 SHALL implement FSM states RUN, DRAIN, REDIRECT, HALT; all control outputs combinational from state and inputs.
REQ-008 Priority in RUN, highest first: i_MEM_Busy, i_EX_TakeBranch, ID trap, load-use stall.
REQ-009 i_MEM_Busy=1 in any state except HALT SHALL assert o_IF_Stall and o_ID_Stall, deassert all flush/redirect/pulse outputs, and freeze state and counters.
REQ-010 RUN, i_EX_TakeBranch=1: o_PC_Redirect=1, o_PC_Target=i_EX_BranchTarget, o_IF_Flush=1, o_ID_Flush=1, same cycle; ID trap flags that cycle SHALL be ignored (wrong path).
REQ-011 RUN, trap = i_ID_Valid and any trap flag: capture o_MEPC=i_ID_PC, o_MCAUSE per REQ-012, load drain counter with 3, assert o_IF_Stall, o_ID_Stall, o_ID_Flush, go to DRAIN.
REQ-012 Cause priority: illegal (2) > ebreak (3) > ecall (11).
REQ-013 Load-use: i_EX_MemRead=1 and i_EX_rd!=0 and i_EX_rd equals i_ID_rs1 or i_ID_rs2 SHALL assert o_IF_Stall, o_ID_Stall, o_ID_Flush for exactly one cycle per occurrence.
REQ-014 DRAIN: assert o_IF_Stall, o_ID_Stall, o_ID_Flush; decrement counter each non-busy cycle; i_EX_TakeBranch ignored; at counter 0 go to REDIRECT (or HALT per REQ-020).
REQ-015 REDIRECT (one cycle): o_PC_Redirect=1, o_PC_Target=i_TrapVector, o_IF_Flush=1, o_ID_Flush=1, o_TrapTaken=1; next state RUN.
REQ-016 Trap entry to redirect latency SHALL be 4 cycles absent i_MEM_Busy (entry cycle + 3 drain), each busy cycle adding one.
REQ-017 o_MEPC/o_MCAUSE SHALL hold until the next trap capture; new trap SHALL NOT be accepted outside RUN.
REQ-018 o_PC_Target SHALL be 0 when o_PC_Redirect=0.

Reset
REQ-019 i_Reset_n=0 SHALL immediately force state RUN, counter 0, o_MEPC=0, o_MCAUSE=0, o_Halted=0, all stall/flush/redirect/pulse outputs 0, including mid-DRAIN or HALT.

Configuration
REQ-020 With TRAP_EBREAK_HALT_EN defined, cause 3 at drain end SHALL enter HALT (o_Halted=1, o_IF_Stall=o_ID_Stall=1, i_MEM_Busy ignored) until i_Resume=1, then REDIRECT to i_TrapVector; undefined, EBREAK SHALL trap like other causes, HALT unreachable, o_Halted tied 0, i_Resume ignored.

Verification
REQ-021 ECALL at PC 0x00000100, vector 0x00000800, no busy -> stalls 4 cycles, then o_PC_Redirect=1 with target 0x800, o_TrapTaken one pulse, o_MEPC=0x100, o_MCAUSE=11.
REQ-022 Same cycle i_EX_TakeBranch=1 target 0x200 and ID illegal -> redirect 0x200 only, state stays RUN, o_MCAUSE unchanged.
REQ-023 EX load rd=5, ID rs2=5 -> one cycle stall+bubble; rd=0, rs1=0 -> no stall.
REQ-024 ECALL with i_MEM_Busy high 2 cycles during DRAIN -> redirect at cycle 6 after entry.
REQ-025 i_Reset_n low during DRAIN -> all outputs 0 immediately, no o_TrapTaken after release.
REQ-026 TRAP_EBREAK_HALT_EN defined, EBREAK at 0x40 -> o_Halted=1 until i_Resume, then redirect to vector, o_MCAUSE=3; undefined -> direct redirect after 4 cycles.

Source files
------------

// File: rtl/pipeline_control.sv
// Pipeline hazard, branch redirect and synchronous trap sequencing for a single-issue core.
// Optional build macro TRAP_EBREAK_HALT_EN: EBREAK parks the core in HALT until i_Resume.
module pipeline_control (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_ID_Valid,
  input  logic        i_ID_EnvCall,
  input  logic        i_ID_EnvBreak,
  input  logic        i_ID_IllegalInstruction,
  input  logic [31:0] i_ID_PC,
  input  logic [4:0]  i_ID_rs1,
  input  logic [4:0]  i_ID_rs2,
  input  logic        i_EX_MemRead,
  input  logic [4:0]  i_EX_rd,
  input  logic        i_EX_TakeBranch,
  input  logic [31:0] i_EX_BranchTarget,
  input  logic        i_MEM_Busy,
  input  logic [31:0] i_TrapVector,
  input  logic        i_Resume,
  output logic        o_IF_Stall,
  output logic        o_ID_Stall,
  output logic        o_IF_Flush,
  output logic        o_ID_Flush,
  output logic        o_PC_Redirect,
  output logic [31:0] o_PC_Target,
  output logic        o_TrapTaken,
  output logic [31:0] o_MEPC,
  output logic [3:0]  o_MCAUSE,
  output logic        o_Halted
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2,
    HALT     = 2'd3
  } state_t;

  state_t      state_r;
  logic [1:0]  cnt_r;
  logic [31:0] mepc_r;
  logic [3:0]  mcause_r;
  logic        trap_s;
  logic        load_use_s;
  logic        if_stall_s;
  logic        id_stall_s;
  logic        if_flush_s;
  logic        id_flush_s;
  logic        redirect_s;
  logic [31:0] target_s;
  logic        trap_taken_s;

  // Illegal outranks ebreak, which outranks ecall.
  function automatic logic [3:0] trap_cause(input logic ill, input logic ebrk, input logic ecall);
    if (ill) begin
      return 4'd2;
    end else if (ebrk) begin
      return 4'd3;
    end else if (ecall) begin
      return 4'd11;
    end else begin
      return 4'd0;
    end
  endfunction

  assign trap_s     = i_ID_Valid && (i_ID_IllegalInstruction || i_ID_EnvBreak || i_ID_EnvCall);
  assign load_use_s = i_EX_MemRead && (i_EX_rd != 5'd0) &&
                      ((i_EX_rd == i_ID_rs1) || (i_EX_rd == i_ID_rs2));

`ifdef TRAP_EBREAK_HALT_EN
  logic halted_r;
  assign o_Halted = halted_r;
`else
  logic unused_resume_s;
  assign unused_resume_s = i_Resume;
  assign o_Halted        = 1'b0;
`endif

  // State, drain counter and captured trap context.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_r  <= RUN;
      cnt_r    <= 2'd0;
      mepc_r   <= 32'd0;
      mcause_r <= 4'd0;
`ifdef TRAP_EBREAK_HALT_EN
      halted_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        RUN: begin
          // A taken branch squashes ID, so its trap flags are wrong-path.
          if (!i_MEM_Busy && !i_EX_TakeBranch && trap_s) begin
            mepc_r   <= i_ID_PC;
            mcause_r <= trap_cause(i_ID_IllegalInstruction, i_ID_EnvBreak, i_ID_EnvCall);
            cnt_r    <= 2'd3;
            state_r  <= DRAIN;
          end
        end
        DRAIN: begin
          if (!i_MEM_Busy) begin
            if (cnt_r <= 2'd1) begin
              cnt_r <= 2'd0;
`ifdef TRAP_EBREAK_HALT_EN
              if (mcause_r == 4'd3) begin
                state_r  <= HALT;
                halted_r <= 1'b1;
              end else begin
                state_r <= REDIRECT;
              end
`else
              state_r <= REDIRECT;
`endif
            end else begin
              cnt_r <= cnt_r - 2'd1;
            end
          end
        end
        REDIRECT: begin
          if (!i_MEM_Busy) begin
            state_r <= RUN;
          end
        end
`ifdef TRAP_EBREAK_HALT_EN
        HALT: begin
          if (i_Resume) begin
            state_r  <= REDIRECT;
            halted_r <= 1'b0;
          end
        end
`endif
        default: begin
          state_r <= RUN;
          cnt_r   <= 2'd0;
        end
      endcase
    end
  end

  // Control outputs decoded from state and live inputs.
  always_comb begin
    if_stall_s   = 1'b0;
    id_stall_s   = 1'b0;
    if_flush_s   = 1'b0;
    id_flush_s   = 1'b0;
    redirect_s   = 1'b0;
    target_s     = 32'd0;
    trap_taken_s = 1'b0;
    if (!i_Reset_n) begin
      if_stall_s = 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (i_MEM_Busy) begin
            if_stall_s = 1'b1;
            id_stall_s = 1'b1;
          end else if (i_EX_TakeBranch) begin
            redirect_s = 1'b1;
            target_s   = i_EX_BranchTarget;
            if_flush_s = 1'b1;
            id_flush_s = 1'b1;
          end else if (trap_s || load_use_s) begin
            if_stall_s = 1'b1;
            id_stall_s = 1'b1;
            id_flush_s = 1'b1;
          end else begin
            if_stall_s = 1'b0;
          end
        end
        DRAIN: begin
          if_stall_s = 1'b1;
          id_stall_s = 1'b1;
          id_flush_s = !i_MEM_Busy;
        end
        REDIRECT: begin
          if (i_MEM_Busy) begin
            if_stall_s = 1'b1;
            id_stall_s = 1'b1;
          end else begin
            redirect_s   = 1'b1;
            target_s     = i_TrapVector;
            if_flush_s   = 1'b1;
            id_flush_s   = 1'b1;
            trap_taken_s = 1'b1;
          end
        end
        HALT: begin
          if_stall_s = 1'b1;
          id_stall_s = 1'b1;
        end
        default: begin
          if_stall_s = 1'b0;
        end
      endcase
    end
  end

  assign o_IF_Stall    = if_stall_s;
  assign o_ID_Stall    = id_stall_s;
  assign o_IF_Flush    = if_flush_s;
  assign o_ID_Flush    = id_flush_s;
  assign o_PC_Redirect = redirect_s;
  assign o_PC_Target   = target_s;
  assign o_TrapTaken   = trap_taken_s;
  assign o_MEPC        = mepc_r;
  assign o_MCAUSE      = mcause_r;

endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboard bench for pipeline_control: stimulus pushes per-cycle expectations, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_pipeline_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, ecall, ebrk, ill;
  logic [31:0] id_pc;
  logic [4:0]  rs1, rs2, ex_rd;
  logic        ex_memread, take_branch, mem_busy, resume;
  logic [31:0] branch_target, trap_vector;
  logic        if_stall, id_stall, if_flush, id_flush, redirect, trap_taken, halted;
  logic [31:0] pc_target, mepc;
  logic [3:0]  mcause;

  typedef struct packed {
    logic [4:0]  ctl;
    logic [31:0] target;
    logic        tt;
    logic [31:0] mepc;
    logic [3:0]  mcause;
    logic        halted;
  } out_t;

  typedef struct {
    string name;
    out_t  v;
  } sb_t;

  sb_t sb_q[$];
  int  total_cnt = 0;
  int  pass_cnt  = 0;

  // ctl = {if_stall, id_stall, if_flush, id_flush, redirect}
  localparam logic [4:0] C_IDLE   = 5'b00000;
  localparam logic [4:0] C_FREEZE = 5'b11000;
  localparam logic [4:0] C_BUBBLE = 5'b11010;
  localparam logic [4:0] C_REDIR  = 5'b00111;

  pipeline_control dut (
    .i_Clock                (clk),
    .i_Reset_n              (rst_n),
    .i_ID_Valid             (id_valid),
    .i_ID_EnvCall           (ecall),
    .i_ID_EnvBreak          (ebrk),
    .i_ID_IllegalInstruction(ill),
    .i_ID_PC                (id_pc),
    .i_ID_rs1               (rs1),
    .i_ID_rs2               (rs2),
    .i_EX_MemRead           (ex_memread),
    .i_EX_rd                (ex_rd),
    .i_EX_TakeBranch        (take_branch),
    .i_EX_BranchTarget      (branch_target),
    .i_MEM_Busy             (mem_busy),
    .i_TrapVector           (trap_vector),
    .i_Resume               (resume),
    .o_IF_Stall             (if_stall),
    .o_ID_Stall             (id_stall),
    .o_IF_Flush             (if_flush),
    .o_ID_Flush             (id_flush),
    .o_PC_Redirect          (redirect),
    .o_PC_Target            (pc_target),
    .o_TrapTaken            (trap_taken),
    .o_MEPC                 (mepc),
    .o_MCAUSE               (mcause),
    .o_Halted               (halted)
  );

  always #5 clk = ~clk;

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_t  e;
      out_t a;
      e = sb_q.pop_front();
      a = '{ctl: {if_stall, id_stall, if_flush, id_flush, redirect}, target: pc_target,
            tt: trap_taken, mepc: mepc, mcause: mcause, halted: halted};
      total_cnt++;
      if (a === e.v) begin
        pass_cnt++;
      end else begin
        $display("FAIL %s: got ctl=%b tgt=%h tt=%b mepc=%h mcause=%0d halted=%b, want ctl=%b tgt=%h tt=%b mepc=%h mcause=%0d halted=%b",
                 e.name, a.ctl, a.target, a.tt, a.mepc, a.mcause, a.halted,
                 e.v.ctl, e.v.target, e.v.tt, e.v.mepc, e.v.mcause, e.v.halted);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string nm, input logic [4:0] ctl, input logic [31:0] tgt,
                      input logic tt, input logic [31:0] ep, input logic [3:0] mc, input logic h);
    sb_t e;
    e.name = nm;
    e.v    = '{ctl: ctl, target: tgt, tt: tt, mepc: ep, mcause: mc, halted: h};
    sb_q.push_back(e);
    tick();
  endtask

  task automatic clear_id();
    id_valid = 1'b0; ecall = 1'b0; ebrk = 1'b0; ill = 1'b0;
  endtask

  // Full trap with no busy: entry, three drain cycles, redirect, then idle.
  task automatic run_trap(input string nm, input logic f_ill, input logic f_eb, input logic f_ec,
                          input logic [31:0] pc, input logic [3:0] cause, input logic [31:0] vec,
                          input logic [31:0] old_pc, input logic [3:0] old_mc);
    id_valid = 1'b1; ill = f_ill; ebrk = f_eb; ecall = f_ec; id_pc = pc; trap_vector = vec;
    step({nm, "_entry"}, C_BUBBLE, 32'd0, 1'b0, old_pc, old_mc, 1'b0);
    clear_id();
    for (int i = 0; i < 3; i++) begin
      take_branch   = (i == 1);
      branch_target = 32'h0000_0300;
      if (i == 2) begin
        id_valid = 1'b1; ill = 1'b1; id_pc = 32'h0000_0DEC;
      end
      step($sformatf("%s_drain%0d", nm, i), C_BUBBLE, 32'd0, 1'b0, pc, cause, 1'b0);
      take_branch = 1'b0;
      clear_id();
    end
    step({nm, "_redirect"}, C_REDIR, vec, 1'b1, pc, cause, 1'b0);
    step({nm, "_after"}, C_IDLE, 32'd0, 1'b0, pc, cause, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; clear_id(); id_pc = 32'd0; rs1 = 5'd0; rs2 = 5'd0; ex_rd = 5'd0;
    ex_memread = 1'b0; mem_busy = 1'b0; resume = 1'b0;
    take_branch = 1'b1; branch_target = 32'h0000_0200; trap_vector = 32'h0000_0800;
    tick();
    step("reset_forces_zero", C_IDLE, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0);
    rst_n = 1'b1; take_branch = 1'b0;
    step("idle_after_reset", C_IDLE, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0);

    run_trap("ecall", 1'b0, 1'b0, 1'b1, 32'h0000_0100, 4'd11, 32'h0000_0800, 32'd0, 4'd0);

    // Branch in the same cycle as an illegal ID instruction wins.
    take_branch = 1'b1; branch_target = 32'h0000_0200;
    id_valid = 1'b1; ill = 1'b1; id_pc = 32'h0000_0444;
    step("branch_over_trap", C_REDIR, 32'h0000_0200, 1'b0, 32'h0000_0100, 4'd11, 1'b0);
    take_branch = 1'b0; clear_id();
    step("branch_stays_run", C_IDLE, 32'd0, 1'b0, 32'h0000_0100, 4'd11, 1'b0);

    // Load-use hazards.
    ex_memread = 1'b1; ex_rd = 5'd5; rs1 = 5'd3; rs2 = 5'd5;
    step("load_use_rs2", C_BUBBLE, 32'd0, 1'b0, 32'h0000_0100, 4'd11, 1'b0);
    ex_memread = 1'b0;
    step("load_use_released", C_IDLE, 32'd0, 1'b0, 32'h0000_0100, 4'd11, 1'b0);
    ex_memread = 1'b1; ex_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    step("load_use_x0", C_IDLE, 32'd0, 1'b0, 32'h0000_0100, 4'd11, 1'b0);
    ex_rd = 5'd7; rs1 = 5'd7; rs2 = 5'd1;
    step("load_use_rs1", C_BUBBLE, 32'd0, 1'b0, 32'h0000_0100, 4'd11, 1'b0);
    ex_memread = 1'b0; ex_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;

    // Busy in RUN outranks branch and trap; nothing captured.
    mem_busy = 1'b1; take_branch = 1'b1; id_valid = 1'b1; ill = 1'b1; id_pc = 32'h0000_0555;
    step("busy_over_all", C_FREEZE, 32'd0, 1'b0, 32'h0000_0100, 4'd11, 1'b0);
    mem_busy = 1'b0; take_branch = 1'b0; clear_id();
    step("busy_no_capture", C_IDLE, 32'd0, 1'b0, 32'h0000_0100, 4'd11, 1'b0);

    // ECALL with two busy cycles in DRAIN: redirect lands six cycles after entry.
    id_valid = 1'b1; ecall = 1'b1; id_pc = 32'h0000_0120; trap_vector = 32'h0000_0800;
    step("busy_entry", C_BUBBLE, 32'd0, 1'b0, 32'h0000_0100, 4'd11, 1'b0);
    clear_id();
    step("busy_drain1", C_BUBBLE, 32'd0, 1'b0, 32'h0000_0120, 4'd11, 1'b0);
    mem_busy = 1'b1;
    step("busy_drain2", C_FREEZE, 32'd0, 1'b0, 32'h0000_0120, 4'd11, 1'b0);
    step("busy_drain3", C_FREEZE, 32'd0, 1'b0, 32'h0000_0120, 4'd11, 1'b0);
    mem_busy = 1'b0;
    step("busy_drain4", C_BUBBLE, 32'd0, 1'b0, 32'h0000_0120, 4'd11, 1'b0);
    step("busy_drain5", C_BUBBLE, 32'd0, 1'b0, 32'h0000_0120, 4'd11, 1'b0);
    mem_busy = 1'b1;
    step("busy_hold_redirect", C_FREEZE, 32'd0, 1'b0, 32'h0000_0120, 4'd11, 1'b0);
    mem_busy = 1'b0;
    step("busy_redirect", C_REDIR, 32'h0000_0800, 1'b1, 32'h0000_0120, 4'd11, 1'b0);
    step("busy_after", C_IDLE, 32'd0, 1'b0, 32'h0000_0120, 4'd11, 1'b0);

    run_trap("cause_prio", 1'b1, 1'b1, 1'b1, 32'h0000_0124, 4'd2, 32'h0000_0900,
             32'h0000_0120, 4'd11);

`ifdef TRAP_EBREAK_HALT_EN
    id_valid = 1'b1; ebrk = 1'b1; id_pc = 32'h0000_0040; trap_vector = 32'h0000_0800;
    step("ebreak_entry", C_BUBBLE, 32'd0, 1'b0, 32'h0000_0124, 4'd2, 1'b0);
    clear_id();
    for (int i = 0; i < 3; i++) begin
      step($sformatf("ebreak_drain%0d", i), C_BUBBLE, 32'd0, 1'b0, 32'h0000_0040, 4'd3, 1'b0);
    end
    step("halt_wait", C_FREEZE, 32'd0, 1'b0, 32'h0000_0040, 4'd3, 1'b1);
    mem_busy = 1'b1;
    step("halt_busy_ignored", C_FREEZE, 32'd0, 1'b0, 32'h0000_0040, 4'd3, 1'b1);
    mem_busy = 1'b0; resume = 1'b1;
    step("halt_resume", C_FREEZE, 32'd0, 1'b0, 32'h0000_0040, 4'd3, 1'b1);
    resume = 1'b0;
    step("halt_redirect", C_REDIR, 32'h0000_0800, 1'b1, 32'h0000_0040, 4'd3, 1'b0);
    step("halt_after", C_IDLE, 32'd0, 1'b0, 32'h0000_0040, 4'd3, 1'b0);
`else
    resume = 1'b1;
    run_trap("ebreak", 1'b0, 1'b1, 1'b0, 32'h0000_0040, 4'd3, 32'h0000_0800,
             32'h0000_0124, 4'd2);
    resume = 1'b0;
`endif

    // Reset in the middle of DRAIN clears everything at once.
    id_valid = 1'b1; ecall = 1'b1; id_pc = 32'h0000_0200;
    step("rst_entry", C_BUBBLE, 32'd0, 1'b0, 32'h0000_0040, 4'd3, 1'b0);
    clear_id();
    step("rst_drain1", C_BUBBLE, 32'd0, 1'b0, 32'h0000_0200, 4'd11, 1'b0);
    rst_n = 1'b0; take_branch = 1'b1; branch_target = 32'h0000_0300;
    step("rst_mid_drain", C_IDLE, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0);
    rst_n = 1'b1; take_branch = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step($sformatf("rst_release%0d", i), C_IDLE, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0);
    end

    @(negedge clk);
    #1;
    total_cnt++;
    if (sb_q.size() == 0) begin
      pass_cnt++;
    end else begin
      $display("FAIL scoreboard_drained: got %0d pending, want 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
